// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game: symbol/pattern geometry, the 4-bit
// state encoding used by the response checker (and visible to the game
// controller), and the hex result codes shown on the display.
package memory_game_pkg;

  localparam int unsigned SYM_W   = 2;   // bits per symbol (4 buttons)
  localparam int unsigned MAX_LEN = 16;  // max symbols per pattern
  localparam int unsigned LEN_W   = 5;   // width of length / step count

  typedef enum logic [3:0] {
    ST_IDLE         = 4'h0,
    ST_WAIT_PRESS   = 4'h1,
    ST_WAIT_RELEASE = 4'h2,
    ST_PASS         = 4'h3,
    ST_FAIL         = 4'h4
  } state_e;

  localparam logic [3:0] RC_IDLE = 4'h0;
  localparam logic [3:0] RC_BUSY = 4'h1;
  localparam logic [3:0] RC_PASS = 4'hA;
  localparam logic [3:0] RC_FAIL = 4'hF;

  function automatic logic [3:0] result_code_of(state_e s);
    logic [3:0] code;
    code = RC_IDLE;
    case (s)
      ST_WAIT_PRESS, ST_WAIT_RELEASE: code = RC_BUSY;
      ST_PASS:                        code = RC_PASS;
      ST_FAIL:                        code = RC_FAIL;
      default:                        code = RC_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/response_checker_if.sv
// Bundle between the game controller (master) and the response checker (slave).
//  start_response : level, high for the whole RESPONSE phase
//  pattern        : symbol i at pattern[i*SYM_W +: SYM_W], symbol 0 first
//  length         : symbols to check this level
//  buttons        : raw active-high button levels
//  done_response  : one-cycle pulse on reaching PASS or FAIL
//  pass           : level result, valid from done_response until IDLE
//  step_count     : correct presses accepted so far
//  result_code    : hex display code (0 idle, 1 busy, A pass, F fail)
interface response_checker_if;
  import memory_game_pkg::*;

  logic                       start_response;
  logic [MAX_LEN*SYM_W-1:0]   pattern;
  logic [LEN_W-1:0]           length;
  logic [3:0]                 buttons;
  logic                       done_response;
  logic                       pass;
  logic [LEN_W-1:0]           step_count;
  logic [3:0]                 result_code;

  modport master (
    output start_response, pattern, length, buttons,
    input  done_response, pass, step_count, result_code
  );

  modport slave (
    input  start_response, pattern, length, buttons,
    output done_response, pass, step_count, result_code
  );

endinterface

// File: rtl/response_checker_debouncer.sv
// button_debouncer: 2-flop synchroniser followed by a stability counter.
// The debounced vector only takes a new value once the synchronised input
// has shown that same value for DEBOUNCE_CYCLES consecutive samples.
//  clk, reset : clock, synchronous active-high reset
//  buttons_i  : raw asynchronous button levels
//  db_o       : debounced button vector
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons_i,
  output logic [3:0] db_o
);

  localparam int unsigned     CNT_W  = 19;
  localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = buttons_i;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    // A changed sample restarts the run at length 1; an equal sample
    // extends it, saturating at the target.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q < TARGET) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d >= TARGET) begin
      db_d = cand_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/response_checker.sv
// response_checker: checks the player's debounced button presses against the
// pattern latched at the start of the RESPONSE phase, with a per-press
// timeout, and reports done/pass, a step count and a hex result code.
//  clk, reset : clock, synchronous active-high reset
//  rc         : controller bundle (slave side), see response_checker_if
module response_checker
  import memory_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic               clk,
  input  logic               reset,
  response_checker_if.slave  rc
);

  localparam int unsigned TMR_W        = 28;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [3:0] db;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .buttons_i (rc.buttons),
    .db_o      (db)
  );

  state_e                   state_q, state_d;
  logic [MAX_LEN*SYM_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]         length_q, length_d;
  logic [LEN_W-1:0]         step_q, step_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [3:0]               code_q, code_d;

  logic [SYM_W-1:0]         exp_sym;
  logic [3:0]               exp_vec;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    length_d  = length_q;
    step_d    = step_q;
    timer_d   = timer_q;

    // Expected button as a one-hot vector: any other non-zero vector
    // (wrong single button or several buttons) is a mismatch.
    exp_sym = SYM_W'(pattern_q >> (int'(step_q) * SYM_W));
    exp_vec = 4'b0001 << exp_sym;

    case (state_q)
      ST_IDLE: begin
        if (rc.start_response) begin
          pattern_d = rc.pattern;
          length_d  = (rc.length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : rc.length;
          step_d    = '0;
          timer_d   = '0;
          state_d   = (rc.length == '0) ? ST_PASS : ST_WAIT_PRESS;
        end
      end
      ST_WAIT_PRESS: begin
        // Button decision is checked before the timeout so it wins a tie.
        if (!rc.start_response) begin
          state_d = ST_IDLE;
        end else if (db != '0) begin
          state_d = (db == exp_vec) ? ST_WAIT_RELEASE : ST_FAIL;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_FAIL;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_RELEASE: begin
        if (!rc.start_response) begin
          state_d = ST_IDLE;
        end else if (db == '0) begin
          step_d  = step_q + LEN_W'(1);
          timer_d = '0;
          state_d = (step_q + LEN_W'(1) == length_q) ? ST_PASS : ST_WAIT_PRESS;
        end else if (db != exp_vec) begin
          state_d = ST_FAIL;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (!rc.start_response) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = ((state_d == ST_PASS) || (state_d == ST_FAIL)) && (state_d != state_q);
    pass_d = (state_d == ST_PASS);
    code_d = result_code_of(state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      length_q  <= '0;
      step_q    <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      code_q    <= RC_IDLE;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      length_q  <= length_d;
      step_q    <= step_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      code_q    <= code_d;
    end
  end

  assign rc.done_response = done_q;
  assign rc.pass          = pass_q;
  assign rc.step_count    = step_q;
  assign rc.result_code   = code_q;

endmodule

// File: tb/tb_response_checker.sv
module tb_response_checker;

  localparam int unsigned DEB = 4;
  localparam int unsigned TO  = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  response_checker_if rc_if();

  response_checker #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rc    (rc_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Count cycles with done_response high; a correct pulse adds exactly 1.
  always @(negedge clk) if (rc_if.done_response === 1'b1) done_cnt <= done_cnt + 1;

  // Game description shared by the model and the driver.
  logic [31:0] g_pat;
  int          g_len;
  logic [3:0]  pv_q[$];   // press vectors
  bit          pl_q[$];   // 1 = player waits past the timeout instead

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: walk the press list against the game rules.
  function automatic void model(output bit ep, output int es, output int nd);
    int eff, idx, sym;
    eff = (g_len > 16) ? 16 : g_len;
    ep = 1'b0; es = 0; nd = 0;
    if (eff == 0) begin ep = 1'b1; return; end
    for (int k = 0; k < pv_q.size(); k++) begin
      if (pl_q[k]) begin nd = k; return; end
      nd = k + 1;
      if ($countones(pv_q[k]) != 1) return;
      idx = 0;
      for (int b = 0; b < 4; b++) if (pv_q[k][b]) idx = b;
      sym = int'((g_pat >> (2 * k)) & 32'h3);
      if (idx != sym) return;
      es++;
      if (es == eff) begin ep = 1'b1; return; end
    end
  endfunction

  task automatic play_game(input string tag);
    bit ep; int es, nd, base, waited;
    model(ep, es, nd);
    base = done_cnt;
    rc_if.pattern        = g_pat;
    rc_if.length         = 5'(g_len);
    rc_if.start_response = 1'b1;
    for (int k = 0; k < nd; k++) begin
      tick($urandom_range(8, 20));
      rc_if.buttons = pv_q[k];
      tick(12);
      rc_if.buttons = '0;
      tick(8);
    end
    waited = 0;
    while (done_cnt == base && waited < 400) begin tick(1); waited++; end
    tick(3);
    check({tag, "_done"}, 32'(done_cnt - base), 32'd1);
    check({tag, "_pass"}, 32'(rc_if.pass), 32'(ep));
    check({tag, "_step"}, 32'(rc_if.step_count), 32'(es));
    check({tag, "_code"}, 32'(rc_if.result_code), ep ? 32'hA : 32'hF);
    rc_if.start_response = 1'b0;
    tick(1);
    check({tag, "_pass_clr"}, 32'(rc_if.pass), 32'd0);
    tick(1);
    check({tag, "_code_idle"}, 32'(rc_if.result_code), 32'd0);
    tick(10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, eff, r, sym;
    logic [3:0] v;
    reset = 1'b1;
    rc_if.start_response = 1'b0;
    rc_if.buttons = '0;
    rc_if.pattern = '0;
    rc_if.length  = '0;
    tick(3);
    check("rst_done", 32'(rc_if.done_response), 32'd0);
    check("rst_pass", 32'(rc_if.pass), 32'd0);
    check("rst_step", 32'(rc_if.step_count), 32'd0);
    check("rst_code", 32'(rc_if.result_code), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: pattern {2,0,1}, correct presses
    g_len = 3; g_pat = 32'h12;
    pv_q = '{4'b0100, 4'b0001, 4'b0010}; pl_q = '{1'b0, 1'b0, 1'b0};
    play_game("t1");
    // 2: b2 then b3 fails on the second press
    pv_q = '{4'b0100, 4'b1000}; pl_q = '{1'b0, 1'b0};
    play_game("t2");

    // 3a: no press -> FAIL exactly at cycle 100 in WAIT_PRESS
    base = done_cnt;
    rc_if.pattern = 32'h6; rc_if.length = 5'd2; rc_if.start_response = 1'b1;
    tick(1);
    tick(99);
    check("t3_c99_nodone", 32'(rc_if.done_response), 32'd0);
    tick(1);
    check("t3_c100_done", 32'(rc_if.done_response), 32'd1);
    check("t3_c100_pass", 32'(rc_if.pass), 32'd0);
    tick(1);
    check("t3_code", 32'(rc_if.result_code), 32'hF);
    rc_if.start_response = 1'b0;
    tick(3);
    // 3b: debounced press lands at cycle 99 -> accepted
    rc_if.start_response = 1'b1;
    tick(1);
    tick(93);
    rc_if.buttons = 4'b0100;
    tick(6);
    check("t3p_c99_nodone", 32'(rc_if.done_response), 32'd0);
    tick(1);
    check("t3p_c100_nodone", 32'(rc_if.done_response), 32'd0);
    check("t3p_c100_busy", 32'(rc_if.result_code), 32'd1);
    rc_if.buttons = '0;
    tick(10);
    check("t3p_step", 32'(rc_if.step_count), 32'd1);
    rc_if.start_response = 1'b0;
    tick(3);
    check("t3_pulses", 32'(done_cnt - base), 32'd1);
    tick(5);

    // 4: bouncing b1 yields one accepted press, then b0+b1 fails
    base = done_cnt;
    rc_if.pattern = 32'h5; rc_if.length = 5'd2; rc_if.start_response = 1'b1;
    tick(5);
    for (int i = 0; i < 10; i++) begin
      rc_if.buttons = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(2);
    end
    rc_if.buttons = 4'b0010;
    tick(12);
    rc_if.buttons = '0;
    tick(10);
    check("t4_one_press", 32'(rc_if.step_count), 32'd1);
    check("t4_no_done", 32'(done_cnt - base), 32'd0);
    rc_if.buttons = 4'b0011;
    tick(12);
    check("t4_multi_done", 32'(done_cnt - base), 32'd1);
    check("t4_multi_pass", 32'(rc_if.pass), 32'd0);
    check("t4_multi_code", 32'(rc_if.result_code), 32'hF);
    rc_if.buttons = '0;
    rc_if.start_response = 1'b0;
    tick(10);

    // 5: abort from WAIT_PRESS, then length 0 passes at once
    base = done_cnt;
    rc_if.pattern = 32'h1B; rc_if.length = 5'd3; rc_if.start_response = 1'b1;
    tick(20);
    check("t5_busy", 32'(rc_if.result_code), 32'd1);
    rc_if.start_response = 1'b0;
    tick(1);
    check("t5_code_lag", 32'(rc_if.result_code), 32'd1);
    check("t5_pass", 32'(rc_if.pass), 32'd0);
    tick(1);
    check("t5_code_idle", 32'(rc_if.result_code), 32'd0);
    check("t5_no_done", 32'(done_cnt - base), 32'd0);
    rc_if.length = 5'd0; rc_if.start_response = 1'b1;
    tick(1);
    check("t5_len0_done", 32'(rc_if.done_response), 32'd1);
    check("t5_len0_pass", 32'(rc_if.pass), 32'd1);
    tick(1);
    check("t5_len0_pulse", 32'(rc_if.done_response), 32'd0);
    check("t5_len0_code", 32'(rc_if.result_code), 32'hA);
    rc_if.start_response = 1'b0;
    tick(5);

    // 6: reset while in WAIT_RELEASE of the second press
    base = done_cnt;
    rc_if.pattern = 32'hE; rc_if.length = 5'd2; rc_if.start_response = 1'b1;
    tick(5);
    rc_if.buttons = 4'b0100; tick(12);
    rc_if.buttons = '0;      tick(10);
    rc_if.buttons = 4'b1000; tick(12);
    check("t6_step_pre", 32'(rc_if.step_count), 32'd1);
    check("t6_no_done", 32'(done_cnt - base), 32'd0);
    reset = 1'b1; rc_if.start_response = 1'b0; rc_if.buttons = '0;
    tick(1);
    check("t6_done", 32'(rc_if.done_response), 32'd0);
    check("t6_pass", 32'(rc_if.pass), 32'd0);
    check("t6_step", 32'(rc_if.step_count), 32'd0);
    check("t6_code", 32'(rc_if.result_code), 32'd0);
    reset = 1'b0;
    tick(10);

    // Randomised games
    for (int g = 0; g < 40; g++) begin
      g_len = $urandom_range(0, 18);
      g_pat = $urandom();
      eff = (g_len > 16) ? 16 : g_len;
      pv_q.delete(); pl_q.delete();
      for (int k = 0; k < eff; k++) begin
        r   = $urandom_range(0, 99);
        sym = int'((g_pat >> (2 * k)) & 32'h3);
        v   = 4'b0001 << sym;
        if (r < 82) begin
          pv_q.push_back(v); pl_q.push_back(1'b0);
        end else if (r < 88) begin
          pv_q.push_back(4'b0001 << ((sym + $urandom_range(1, 3)) % 4)); pl_q.push_back(1'b0);
        end else if (r < 94) begin
          pv_q.push_back(v | (4'b0001 << ((sym + $urandom_range(1, 3)) % 4))); pl_q.push_back(1'b0);
        end else begin
          pv_q.push_back(v); pl_q.push_back(1'b1);
        end
      end
      play_game($sformatf("rnd%0d", g));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
